note_sequence_reader: RTL

//  Multi-track note-memory address sequencer for the song/record path; successor to the single-track note read counter.

---
 rtl/note_sequence_reader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/note_sequence_reader.sv
// Multi-track note-memory read address sequencer: steps through the selected
// track's table on each read strobe, with per-track limits, looping and pause.
module note_sequence_reader #(
   parameter int ADDR_W     = 7,
   parameter int NUM_TRACKS = 2,
   parameter int TRK_W      = 1,
   parameter int CNT_W      = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         listen,
   input  logic                         start,
   input  logic                         read,
   input  logic                         pause,
   input  logic                         loop_en,
   input  logic [TRK_W-1:0]             track_sel,
   input  logic [NUM_TRACKS*ADDR_W-1:0] limits,
   output logic [ADDR_W-1:0]            read_addr,
   output logic [TRK_W-1:0]             active_track,
   output logic                         finish,
   output logic                         wrap,
   output logic                         busy,
   output logic [CNT_W-1:0]             loop_count,
   output logic [1:0]                   state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PLAY   = 2'd1,
      S_PAUSED = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   lim_q, lim_d, lim_sel;
   logic [ADDR_W-1:0]   addr_d;
   logic [TRK_W-1:0]    trk_d;
   logic [CNT_W-1:0]    cnt_d;
   logic                wrap_d;
   logic                track_ok;
   logic                start_ok;
   logic                at_limit;

   // Out-of-range track selects match no entry and so leave start_ok low.
   always_comb begin
      track_ok = 1'b0;
      lim_sel  = '0;
      for (int t = 0; t < NUM_TRACKS; t++) begin
         if (track_sel == TRK_W'(t)) begin
            track_ok = 1'b1;
            lim_sel  = limits[t*ADDR_W +: ADDR_W];
         end
      end
   end

   assign start_ok = start && track_ok;
   // Compare before increment so the address never passes the limit.
   assign at_limit = (read_addr >= lim_q);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         lim_q        <= '0;
         read_addr    <= '0;
         active_track <= '0;
         loop_count   <= '0;
         wrap         <= 1'b0;
         busy         <= 1'b0;
         finish       <= 1'b0;
      end else begin
         state_q      <= state_d;
         lim_q        <= lim_d;
         read_addr    <= addr_d;
         active_track <= trk_d;
         loop_count   <= cnt_d;
         wrap         <= wrap_d;
         busy         <= (state_d == S_PLAY) || (state_d == S_PAUSED);
         finish       <= (state_d == S_DONE);
      end
   end

   always_comb begin
      state_d = state_q;
      if (listen) begin
         state_d = S_IDLE;
      end else if (start_ok) begin
         state_d = S_PLAY;
      end else begin
         case (state_q)
            S_PLAY: begin
               if (pause)                             state_d = S_PAUSED;
               else if (read && at_limit && !loop_en) state_d = S_DONE;
            end
            S_PAUSED: if (!pause) state_d = S_PLAY;
            default:  state_d = state_q;
         endcase
      end
   end

   // Next values of the registered datapath outputs.
   always_comb begin
      addr_d = read_addr;
      trk_d  = active_track;
      cnt_d  = loop_count;
      lim_d  = lim_q;
      wrap_d = 1'b0;
      if (listen) begin
         addr_d = '0;
         cnt_d  = '0;
      end else if (start_ok) begin
         trk_d  = track_sel;
         lim_d  = lim_sel;
         addr_d = '0;
         cnt_d  = '0;
      end else if (state_q == S_PLAY && !pause && read) begin
         if (!at_limit) begin
            addr_d = read_addr + ADDR_W'(1);
         end else begin
            addr_d = '0;
            if (loop_en) begin
               wrap_d = 1'b1;
               if (loop_count != {CNT_W{1'b1}}) cnt_d = loop_count + CNT_W'(1);
            end
         end
      end
   end

   assign state_dbg = state_q;

endmodule
